serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial two's-complement subtractor: computes diff = a - b one bit per clock, LSB first.
//   Uses a single full-adder cell (a_i + ~b_i + carry) plus a carry flip-flop.
//   Companion to the combinational full-adder datapath; it is the subtract direction for the ALU.
//   Trades latency for area; a start/ready/done handshake frames each operation.
// PARAMETERS
//   WIDTH  4  operand and result width in bits (>= 2)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   reset      in   1      synchronous, active-high reset
//   start      in   1      request; sampled only when ready=1
//   a          in   WIDTH  minuend; captured on the accepted start
//   b          in   WIDTH  subtrahend; captured on the accepted start
//   ready      out  1      1 in IDLE and DONE; a start is accepted when ready=1
//   busy       out  1      1 while bits are being computed (SHIFT state)
//   done       out  1      one-cycle pulse; diff/borrowout/overflow valid from this cycle
//   diff       out  WIDTH  a - b modulo 2^WIDTH
//   borrowout  out  1      1 iff unsigned a < unsigned b (inverse of the final carry)
//   overflow   out  1      1 iff the signed result overflowed
// BEHAVIOUR
//   Clock/reset: one clock; reset is synchronous and active-high.
//   Reset: state=IDLE, ready=1, busy=0, done=0, diff=0, borrowout=0, overflow=0.
//     Bit counter, carry and operand shift registers are cleared.
//   States:
//     IDLE --start--> SHIFT
//     SHIFT --(WIDTH bits done)--> DONE
//     DONE --start--> SHIFT
//     DONE --no start--> IDLE
//   Accept (IDLE or DONE with start=1):
//     Load the a and b shift registers, set carry=1, set bit counter=0, clear diff.
//     Go to SHIFT next cycle.
//   SHIFT, each cycle:
//     s = a_lsb ^ ~b_lsb ^ carry
//     carry <= majority(a_lsb, ~b_lsb, carry)
//     Shift s into diff from the MSB end; shift a and b right one bit; counter++.
//     At the last bit (counter = WIDTH-1), also record c_msb_in = carry before the update.
//   SHIFT lasts exactly WIDTH cycles.
//   DONE (1 cycle): done=1 and diff holds the full result.
//     borrowout = ~final_carry
//     overflow = c_msb_in ^ final_carry
//   Latency: start sampled at edge T -> done high in the cycle after edge T+WIDTH.
//     That is WIDTH+1 cycles from acceptance to done.
//   Outputs hold their values after DONE until the next accepted start or a reset.
//   start while busy=1: ignored; no effect on the in-flight operation or the captured operands.
//   a and b may change freely after acceptance.
//   Back-to-back: a start during DONE is accepted and the next op enters SHIFT with no idle gap.
//   Reset mid-SHIFT: aborts the operation. All outputs take their reset values next cycle
//     and no done pulse is issued.
//   reset and start in the same cycle: reset wins; start is dropped.
//   Arithmetic is modulo 2^WIDTH; no saturation.
// TESTING (WIDTH=4)
//   1. a=0111, b=0011, start 1 cycle -> busy for 4 cycles, done at cycle 5;
//      diff=0100, borrowout=0, overflow=0.
//   2. a=0011, b=0111 -> diff=1100, borrowout=1, overflow=0.
//   3. a=1000, b=0001 -> diff=0111, borrowout=0, overflow=1;
//      then a=0101, b=1000 -> diff=1101, borrowout=1, overflow=1.
//   4. a=0110, b=0110 then a=0000, b=0000 -> diff=0000, borrowout=0, overflow=0 both times;
//      second op started during the DONE cycle of the first, no gap.
//   5. Start with a=0111, b=0011; assert start again with a=0000 on cycle 2 ->
//      ignored; result is still diff=0100 at cycle 5.
//   6. Reset on cycle 2 of SHIFT -> next cycle ready=1, busy=0, diff=0;
//      no done pulse over the next 8 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-adder cell computes a + ~b + 1
// one bit per clock, LSB first, framed by a start/ready/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             nb, s, c_new, last, accept;

  // Single full-adder cell: subtraction as a + ~b with carry seeded to 1
  assign nb     = ~b_sr[0];
  assign s      = a_sr[0] ^ nb ^ carry;
  assign c_new  = (a_sr[0] & nb) | (a_sr[0] & carry) | (nb & carry);
  assign last   = (state == SHIFT) && (cnt == CW'(WIDTH-1));
  assign accept = ready && start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr      <= '0;
      b_sr      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      diff      <= '0;
      borrowout <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_sr      <= a;
      b_sr      <= b;
      cnt       <= '0;
      carry     <= 1'b1;
      diff      <= '0;
      borrowout <= 1'b0;
      overflow  <= 1'b0;
    end else if (busy) begin
      diff  <= {s, diff[WIDTH-1:1]};
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      carry <= c_new;
      cnt   <= cnt + CW'(1);
      // carry here is the carry into the MSB; c_new is the final carry out
      if (last) begin
        borrowout <= ~c_new;
        overflow  <= carry ^ c_new;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes arithmetic-model results on
// each accepted start, a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] a, b;
  logic         ready, busy, done, borrowout, overflow;
  logic [W-1:0] diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .diff(diff),
    .borrowout(borrowout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned and signed views
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    exp_t e;
    int r, sa, sb, sr;
    r    = int'(ta) - int'(tb_v);
    e.d  = r[W-1:0];
    e.bo = (ta < tb_v);
    sa   = (ta >= (1 << (W-1))) ? int'(ta) - (1 << W) : int'(ta);
    sb   = (tb_v >= (1 << (W-1))) ? int'(tb_v) - (1 << W) : int'(tb_v);
    sr   = sa - sb;
    e.ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("diff", diff, e.d);
        chk("borrowout", borrowout, e.bo);
        chk("overflow", overflow, e.ov);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Waits for ready, presents one start, and queues the expected result if it should complete
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit expect_it);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", 0, 1);
    a = ta; b = tb_v; start = 1'b1;
    e = model(ta, tb_v);
    e.cyc = cyc + 1 + W;
    @(posedge clk);
    if (expect_it) q.push_back(e);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_diff"}, diff, 0);
    chk({tag, "_borrowout"}, borrowout, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;

    // Directed cases with busy-duration check on the first
    do_op(4'b0111, 4'b0011, 1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("busy_shift", busy, 1);
    end
    drain();
    do_op(4'b0011, 4'b0111, 1);
    drain();
    do_op(4'b1000, 4'b0001, 1);
    do_op(4'b0101, 4'b1000, 1);
    drain();
    do_op(4'b0110, 4'b0110, 1);
    do_op(4'b0000, 4'b0000, 1);
    drain();

    // Start while busy must be ignored
    do_op(4'b0111, 4'b0011, 1);
    @(negedge clk);
    chk("busy_ignore", busy, 1);
    start = 1'b1; a = '0; b = '0;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset during the second SHIFT cycle aborts without a done pulse
    do_op(4'b1001, 4'b0010, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle_outputs("abort");
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end

    // Reset wins over a simultaneous start
    reset = 1'b1; start = 1'b1; a = 4'b0101; b = 4'b0001;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_ready", ready, 1);
    repeat (W + 2) begin
      @(negedge clk);
      chk("rst_start_no_done", done, 0);
    end

    // Random operands, mixing back-to-back and gapped issue
    repeat (40) begin
      do_op(W'($urandom), W'($urandom), 1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
